// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_stage                                               |
// | Purpose  : Instruction fetch stage. Holds the fetch PC, presents it  |
// |            to a combinational instruction memory and registers the  |
// |            returned word into the IF/ID pipeline register. Handles  |
// |            decode stalls, redirects from later stages, a sticky     |
// |            misaligned-target flag and an accepted-fetch counter.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fetch_stage #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_init,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] program_counter,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid,
  output logic              pc_misaligned,
  output logic [31:0]       fetch_count
);

  // Mask that clears the two byte-offset bits of an address.
  localparam logic [ADDR_W-1:0] C_WORD_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc_plus4;
  logic              r_valid;
  logic              r_misaligned;
  logic [31:0]       r_fetch_count;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_target_misaligned;

  // Sequential PC increment (wraps naturally at the top of the address space)
  // and detection of a redirect target that is not word aligned.
  always_comb begin
    w_pc_plus4          = r_pc + ADDR_W'(4);
    w_target_misaligned = (redirect_target[1:0] != 2'b00);
  end

  // Fetch state update: reset beats redirect, redirect beats stall, and only
  // a clean cycle advances the PC and loads a real instruction into IF/ID.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= pc_init & C_WORD_MASK;
      r_instr       <= NOP_WORD;
      r_pc_plus4    <= '0;
      r_valid       <= 1'b0;
      r_misaligned  <= 1'b0;
      r_fetch_count <= '0;
    end else if (redirect) begin
      // Squash whatever is in IF/ID; the target is forced word aligned but a
      // bad target is remembered until the next reset.
      r_pc       <= redirect_target & C_WORD_MASK;
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
      if (w_target_misaligned) begin
        r_misaligned <= 1'b1;
      end
    end else if (!stall) begin
      r_pc          <= w_pc_plus4;
      r_instr       <= imem_rdata;
      r_pc_plus4    <= w_pc_plus4;
      r_valid       <= 1'b1;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  // Output drive: memory is addressed directly by the registered PC.
  always_comb begin
    imem_addr       = r_pc;
    program_counter = r_pc;
    if_id_instr     = r_instr;
    if_id_pc_plus4  = r_pc_plus4;
    if_id_valid     = r_valid;
    pc_misaligned   = r_misaligned;
    fetch_count     = r_fetch_count;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: ADDR_W, 32, PC and address width in bits.
REQ-002 Parameter: NOP_WORD, 32'h0000_0000, instruction word injected as a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 pc_init  input  32  start PC, sampled every cycle rst_n is low.
REQ-006 stall  input  1  hazard stall from decode; hold PC and IF/ID.
REQ-007 redirect  input  1  taken branch/jump from a later stage.
REQ-008 redirect_target  input  32  new PC when redirect is high.
REQ-009 imem_addr  output  32  byte address to instruction memory (combinational read).
REQ-010 imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle.
REQ-011 program_counter  output  32  current fetch PC (registered).
REQ-012 if_id_instr  output  32  registered instruction to decode.
REQ-013 if_id_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-014 if_id_valid  output  1  high when if_id_instr is a real fetched instruction.
REQ-015 pc_misaligned  output  1  sticky flag: a redirect target had nonzero bits [1:0].
REQ-016 fetch_count  output  32  number of instructions accepted into IF/ID.

Function
REQ-017 imem_addr SHALL equal program_counter combinationally.
REQ-018 Normal cycle (no stall, no redirect): program_counter <= program_counter+4 mod 2^32; IF/ID <= {imem_rdata, program_counter+4, valid=1}; fetch_count +1.
REQ-019 Stall only: program_counter, IF/ID, fetch_count SHALL hold.
REQ-020 Redirect (with or without stall): program_counter <= {redirect_target[31:2],2'b00}; IF/ID <= {NOP_WORD, 0, valid=0}; fetch_count holds; redirect has priority over stall.
REQ-021 Redirect with redirect_target[1:0]!=0 SHALL set pc_misaligned=1 until reset; target still forced word-aligned.
REQ-022 PC wrap: 32'hFFFF_FFFC +4 SHALL give 32'h0000_0000, if_id_pc_plus4=0, no flag.
REQ-023 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-024 Latency: instruction at PC p appears on if_id_instr one cycle after program_counter==p with no stall/redirect in that cycle.
REQ-025 Back-to-back redirects SHALL each take effect; only the last cycle's target is fetched next.
REQ-026 No internal state machine beyond the above; behaviour is fully defined by stall/redirect per cycle.

Reset
REQ-027 While rst_n=0 at a rising edge: program_counter <= {pc_init[31:2],2'b00}; if_id_instr=NOP_WORD; if_id_pc_plus4=0; if_id_valid=0; pc_misaligned=0; fetch_count=0.
REQ-028 Reset SHALL override stall and redirect, including mid-stall and during a redirect cycle.
REQ-029 First fetch occurs on the first rising edge with rst_n=1.

Verification
REQ-030 pc_init=200, release reset, no stall, imem returns addr-based words -> program_counter 200,204,208; if_id_pc_plus4 204 one cycle later, valid=1, fetch_count=1.
REQ-031 Running at PC=212, stall high 3 cycles -> program_counter stays 212, IF/ID unchanged, fetch_count unchanged; resumes 216 after stall drops.
REQ-032 At PC=220, redirect=1, target=400, stall=1 same cycle -> program_counter=400, if_id_valid=0, if_id_instr=0, next cycle fetches 400.
REQ-033 Redirect target=402 -> program_counter=400, pc_misaligned=1 and stays 1 until rst_n low.
REQ-034 Redirect to 32'hFFFF_FFFC, run 2 cycles -> program_counter=0, if_id_pc_plus4=0, valid=1.
REQ-035 Assert rst_n=0 during stall with pc_init=200 -> next edge program_counter=200, all outputs at reset values.
